// File: rtl/pe_pkg.sv
// Shared PE-array definitions: default counter width and dispatcher FSM encodings.
package pe_pkg;

    localparam int unsigned PE_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } pe_state_e;

endpackage

// File: rtl/pe_dispatch_cnt.sv
// Job index counter with enable, synchronous clear and terminal-count flag (idx == num_jobs-1).
module pe_dispatch_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] num_jobs,
    output logic [W-1:0] idx,
    output logic         tc_c
);

    assign tc_c = (idx == (num_jobs - W'(1)));

    // Holds at the terminal index so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en && !tc_c) begin
            idx <= idx + W'(1);
        end
    end

endmodule

// File: rtl/pe_dispatcher.sv
// Initiator side of the PE valid/ack/ready handshake: issues a batch of job indices, drains, pulses done.
// Optional PE_DISPATCH_STATS_EN build adds stall_cnt and proto_err outputs.
module pe_dispatcher
    import pe_pkg::*;
#(
    parameter int unsigned CNT_W = PE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_jobs,
    input  logic             abort,
    input  logic             pe_ack,
    input  logic             pe_ready,
    output logic             o_valid,
    output logic [CNT_W-1:0] job_idx,
    output logic             busy,
    output logic             done
`ifdef PE_DISPATCH_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic             proto_err
`endif
);

    pe_state_e        state_q;
    pe_state_e        state_d;
    logic             o_valid_d;
    logic             done_d;
    logic             drain_first_q;
    logic             drain_first_d;
    logic [CNT_W-1:0] jobs_q;
    logic             start_acc;
    logic             cnt_en;
    logic             tc_c;

    assign start_acc = (state_q == IDLE) && start;
    assign cnt_en    = (state_q == ISSUE) && pe_ack;

    pe_dispatch_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc),
        .en       (cnt_en),
        .num_jobs (jobs_q),
        .idx      (job_idx),
        .tc_c     (tc_c)
    );

    // Next state and next registered outputs; o_valid only falls on the terminal ack or abort.
    always_comb begin
        state_d       = state_q;
        o_valid_d     = o_valid;
        done_d        = 1'b0;
        drain_first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_jobs != '0) begin
                        state_d   = ISSUE;
                        o_valid_d = 1'b1;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if ((pe_ack && tc_c) || abort) begin
                    state_d       = DRAIN;
                    o_valid_d     = 1'b0;
                    drain_first_d = 1'b1;
                end
            end
            DRAIN: begin
                // The PE is busy right after an ack, so the first DRAIN cycle's pe_ready is stale.
                if (!drain_first_q && pe_ready) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                o_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            o_valid       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            drain_first_q <= 1'b0;
            jobs_q        <= '0;
        end else begin
            state_q       <= state_d;
            o_valid       <= o_valid_d;
            busy          <= (state_d != IDLE);
            done          <= done_d;
            drain_first_q <= drain_first_d;
            if (start_acc) begin
                jobs_q <= num_jobs;
            end
        end
    end

`ifdef PE_DISPATCH_STATS_EN
    // Saturating stall counter and sticky ack-without-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            proto_err <= 1'b0;
        end else begin
            if (start_acc) begin
                stall_cnt <= '0;
            end else if (o_valid && !pe_ack && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (pe_ack && !o_valid) begin
                proto_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_dispatcher.sv
// Directed bench for pe_dispatcher with a latency-L PE model (ack when idle, ready in last busy cycle).
module tb_pe_dispatcher;
    import pe_pkg::*;

    localparam int unsigned W = PE_CNT_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] num_jobs = '0;
    logic         pe_ack;
    logic         pe_ready;
    logic         o_valid;
    logic [W-1:0] job_idx;
    logic         busy;
    logic         done;
`ifdef PE_DISPATCH_STATS_EN
    logic [31:0]  stall_cnt;
    logic         proto_err;
`endif

    int           pe_cnt;
    int           pe_lat = 3;
    logic         err_ack = 1'b0;
    int           ack_cnt;
    int           done_cnt;
    logic [W-1:0] idx_log [16];
    int           n_tests = 0;
    int           n_fail = 0;

    pe_dispatcher #(.CNT_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_jobs (num_jobs),
        .abort    (abort),
        .pe_ack   (pe_ack),
        .pe_ready (pe_ready),
        .o_valid  (o_valid),
        .job_idx  (job_idx),
        .busy     (busy),
        .done     (done)
`ifdef PE_DISPATCH_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .proto_err(proto_err)
`endif
    );

    always #5 clk = ~clk;

    // PE model: the ack cycle is the first of pe_lat busy cycles.
    assign pe_ack   = (o_valid && (pe_cnt == 0)) || err_ack;
    assign pe_ready = (pe_cnt <= 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_cnt <= 0;
        else if (o_valid && pe_ack) pe_cnt <= pe_lat - 1;
        else if (pe_cnt > 0) pe_cnt <= pe_cnt - 1;
    end

    always @(posedge clk) begin
        if (rst_n && o_valid && pe_ack) begin
            if (ack_cnt < 16) idx_log[ack_cnt] = job_idx;
            ack_cnt++;
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ack_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic launch(input int n);
        num_jobs = W'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_acks(input int n);
        int cyc;
        cyc = 0;
        while (ack_cnt < n && cyc < 100) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (ack_cnt != n) begin
            n_fail++;
            $display("FAIL wait_acks: got %0d acks, expected %0d", ack_cnt, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({o_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got v/b/d=%b, expected 000", {o_valid, busy, done});
        end
        n_tests++;
        if (job_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_idx: got %0d, expected 0", job_idx);
        end
`ifdef PE_DISPATCH_STATS_EN
        n_tests++;
        if (stall_cnt !== 32'd0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stats: got stall=%0d err=%b, expected 0/0", stall_cnt, proto_err);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_batch4();
        int cyc;
        int gap;
        clear_mon();
        pe_lat = 3;
        launch(4);
        n_tests++;
        if (o_valid !== 1'b1 || busy !== 1'b1 || job_idx !== W'(0)) begin
            n_fail++;
            $display("FAIL b4_first: got v=%b b=%b idx=%0d, expected 1 1 0", o_valid, busy, job_idx);
        end
        cyc = 1;
        gap = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (ack_cnt < 4 && o_valid !== 1'b1) gap++;
            if (busy !== 1'b1) gap++;
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc != 13) begin
            n_fail++;
            $display("FAIL b4_done_cycle: got %0d, expected 13", cyc);
        end
        n_tests++;
        if (gap != 0) begin
            n_fail++;
            $display("FAIL b4_valid_busy_gap: got %0d gap cycles, expected 0", gap);
        end
        n_tests++;
        if (ack_cnt != 4) begin
            n_fail++;
            $display("FAIL b4_acks: got %0d, expected 4", ack_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (idx_log[i] !== W'(i)) begin
                n_fail++;
                $display("FAIL b4_idx%0d: got %0d, expected %0d", i, idx_log[i], i);
            end
        end
        n_tests++;
        if (busy !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b4_at_done: got b=%b v=%b, expected 1 0", busy, o_valid);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL b4_after: got b=%b d=%b dcnt=%0d, expected 0 0 1", busy, done, done_cnt);
        end
    endtask

    task automatic test_zero_jobs();
        clear_mon();
        launch(0);
        n_tests++;
        if (o_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_fin: got v=%b b=%b d=%b, expected 0 1 1", o_valid, busy, done);
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ack_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_idle: got v=%b b=%b d=%b acks=%0d, expected 0 0 0 0",
                     o_valid, busy, done, ack_cnt);
        end
    endtask

    task automatic test_abort_no_ack();
        clear_mon();
        launch(5);
        wait_acks(2);
        abort = 1'b1;
        tick();
        n_tests++;
        if (o_valid !== 1'b0 || job_idx !== W'(2)) begin
            n_fail++;
            $display("FAIL abort_drop: got v=%b idx=%0d, expected 0 2", o_valid, job_idx);
        end
        tick();
        abort = 1'b0;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_first_drain: got done=%b, expected 0", done);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || ack_cnt != 2) begin
            n_fail++;
            $display("FAIL abort_done: got d=%b acks=%0d, expected 1 2", done, ack_cnt);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_idle: got b=%b dcnt=%0d, expected 0 1", busy, done_cnt);
        end
    endtask

    task automatic test_abort_with_ack();
        clear_mon();
        launch(5);
        wait_acks(2);
        tick();
        tick();
        n_tests++;
        if (pe_ack !== 1'b1 || job_idx !== W'(2)) begin
            n_fail++;
            $display("FAIL abortack_pre: got ack=%b idx=%0d, expected 1 2", pe_ack, job_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || job_idx !== W'(3) || ack_cnt != 3) begin
            n_fail++;
            $display("FAIL abortack_drop: got v=%b idx=%0d acks=%0d, expected 0 3 3",
                     o_valid, job_idx, ack_cnt);
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abortack_wait: got done=%b, expected 0", done);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abortack_done: got d=%b b=%b, expected 1 1", done, busy);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int cyc;
        clear_mon();
        launch(3);
        tick();
        num_jobs = W'(7);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        tick();
        repeat (3) tick();
        n_tests++;
        if (ack_cnt != 3 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL busy_start: got acks=%0d dones=%0d, expected 3 1", ack_cnt, done_cnt);
        end
        n_tests++;
        if (idx_log[0] !== W'(0) || idx_log[1] !== W'(1) || idx_log[2] !== W'(2)) begin
            n_fail++;
            $display("FAIL busy_start_idx: got %0d,%0d,%0d, expected 0,1,2",
                     idx_log[0], idx_log[1], idx_log[2]);
        end
        n_tests++;
        if (busy !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_idle: got b=%b v=%b, expected 0 0", busy, o_valid);
        end
    endtask

    task automatic test_abort_idle_fin();
        clear_mon();
        abort = 1'b1;
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b0 || o_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got b=%b v=%b d=%b, expected 0 0 0", busy, o_valid, done);
        end
        abort = 1'b0;
        launch(0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_fin: got b=%b dcnt=%0d, expected 0 1", busy, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        launch(5);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_valid, busy, done} !== 3'b000 || job_idx !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got v/b/d=%b idx=%0d, expected 000 0", {o_valid, busy, done}, job_idx);
        end
        tick();
        #2;
        rst_n = 1'b1;
        repeat (5) tick();
        n_tests++;
        if (done_cnt != 0 || o_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: got dcnt=%0d v=%b b=%b, expected 0 0 0", done_cnt, o_valid, busy);
        end
    endtask

`ifdef PE_DISPATCH_STATS_EN
    task automatic test_stats();
        int cyc;
        clear_mon();
        pe_lat = 3;
        launch(3);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (stall_cnt !== 32'd4 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stats_stall: got stall=%0d err=%b, expected 4 0", stall_cnt, proto_err);
        end
        tick();
        err_ack = 1'b1;
        tick();
        err_ack = 1'b0;
        tick();
        n_tests++;
        if (proto_err !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stats_proto: got err=%b b=%b v=%b, expected 1 0 0", proto_err, busy, o_valid);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        ack_cnt  = 0;
        done_cnt = 0;
        test_reset();
        test_batch4();
        test_zero_jobs();
        test_abort_no_ack();
        test_abort_with_ack();
        test_start_while_busy();
        test_abort_idle_fin();
        test_reset_mid();
`ifdef PE_DISPATCH_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
